regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file writeback
// arbiter and its pending-write scoreboard.
//   DATA_W        default writeback data width
//   REG_IDX_W     register index width
//   NUM_ARCH_REGS writable architectural registers (R0-R14)
//   PC_IDX        index 15, the PC, which is never a legal writeback target
//   req_src_e     which requester won arbitration this cycle
package regfile_pkg;

  localparam int DATA_W        = 32;
  localparam int REG_IDX_W     = 4;
  localparam int NUM_ARCH_REGS = 15;
  localparam int PC_IDX        = 15;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_ALU,
    REQ_MEM
  } req_src_e;

  // True for R0-R14; index 15 has no busy flag and no register-file slot.
  function automatic logic is_arch_reg(input logic [REG_IDX_W-1:0] idx);
    return idx < REG_IDX_W'(NUM_ARCH_REGS);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write flags for R0-R14.
//   clk_i, rst_ni       clock, async active-low reset
//   claim_en_i/_reg_i   issue stage marks a destination as pending
//   clr_en_i/_reg_i     committed register-file write clears the flag
//   busy_o              one flag per architectural register
// A claim and a clear of the same register on one edge leave it busy: the
// new claim belongs to a younger instruction than the write that retires.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     claim_en_i,
  input  logic [REG_IDX_W-1:0]     claim_reg_i,
  input  logic                     clr_en_i,
  input  logic [REG_IDX_W-1:0]     clr_reg_i,
  output logic [NUM_ARCH_REGS-1:0] busy_o
);

  logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    // Clear first so a same-edge claim overrides it.
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      if (clr_en_i && clr_reg_i == REG_IDX_W'(r)) busy_d[r] = 1'b0;
    end
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      if (claim_en_i && is_arch_reg(claim_reg_i) && claim_reg_i == REG_IDX_W'(r))
        busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and load writebacks onto the single
// register-file write port, with starvation protection for the ALU.
//   clk, rst                      clock, async active-low reset
//   alu_req/_dst/_val, alu_gnt    ALU writeback request and grant
//   mem_req/_dst/_val, mem_gnt    load writeback request and grant
//   wb_en, dst, wb_val            registered register-file write port
//   claim_en, claim_reg           issue-stage pending-write claim
//   busy                          pending-write flags R0-R14
//   pc_wb_err                     pulse: a granted write targeted R15
// Build option: REGFILE_WB_SCOREBOARD_EN adds busy tracking; without it
// busy reads 0 and the claim inputs are ignored.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_req,
  input  logic [REG_IDX_W-1:0]     alu_dst,
  input  logic [DATA_W-1:0]        alu_val,
  output logic                     alu_gnt,
  input  logic                     mem_req,
  input  logic [REG_IDX_W-1:0]     mem_dst,
  input  logic [DATA_W-1:0]        mem_val,
  output logic                     mem_gnt,
  output logic                     wb_en,
  output logic [REG_IDX_W-1:0]     dst,
  output logic [DATA_W-1:0]        wb_val,
  input  logic                     claim_en,
  input  logic [REG_IDX_W-1:0]     claim_reg,
  output logic [NUM_ARCH_REGS-1:0] busy,
  output logic                     pc_wb_err
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]     starve_q, starve_d;
  req_src_e             sel;
  logic                 force_alu;
  logic [REG_IDX_W-1:0] sel_dst;
  logic [DATA_W-1:0]    sel_val;

  logic                 wb_en_q, wb_en_d;
  logic                 err_q, err_d;
  logic [REG_IDX_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0]    val_q, val_d;

  // Arbitration: MEM normally wins; a starved ALU takes the port. Grants
  // are forced low while reset is held.
  always_comb begin
    force_alu = alu_req && (starve_q == LIMIT);
    sel       = REQ_NONE;
    if (!rst)                       sel = REQ_NONE;
    else if (mem_req && !force_alu) sel = REQ_MEM;
    else if (alu_req)               sel = REQ_ALU;
  end

  assign alu_gnt = (sel == REQ_ALU);
  assign mem_gnt = (sel == REQ_MEM);

  // Consecutive ALU denials; any cycle without a waiting ALU restarts it.
  always_comb begin
    starve_d = '0;
    if (alu_req && !alu_gnt)
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + CNT_W'(1);
  end

  always_comb begin
    sel_dst = (sel == REQ_ALU) ? alu_dst : mem_dst;
    sel_val = (sel == REQ_ALU) ? alu_val : mem_val;
  end

  // Write stage. A grant to R15 is consumed without touching the register
  // file; dst/wb_val keep the last real write so they stay stable.
  always_comb begin
    wb_en_d = 1'b0;
    err_d   = 1'b0;
    dst_d   = dst_q;
    val_d   = val_q;
    if (sel != REQ_NONE) begin
      if (sel_dst == REG_IDX_W'(PC_IDX)) begin
        err_d = 1'b1;
      end else begin
        wb_en_d = 1'b1;
        dst_d   = sel_dst;
        val_d   = sel_val;
      end
    end
  end

  // Async reset also discards a grant captured but not yet written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      wb_en_q  <= 1'b0;
      err_q    <= 1'b0;
      dst_q    <= '0;
      val_q    <= '0;
    end else begin
      starve_q <= starve_d;
      wb_en_q  <= wb_en_d;
      err_q    <= err_d;
      dst_q    <= dst_d;
      val_q    <= val_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign dst       = dst_q;
  assign wb_val    = val_q;
  assign pc_wb_err = err_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  regfile_scoreboard u_sb (
    .clk_i       (clk),
    .rst_ni      (rst),
    .claim_en_i  (claim_en),
    .claim_reg_i (claim_reg),
    .clr_en_i    (wb_en_q),
    .clr_reg_i   (dst_q),
    .busy_o      (busy)
  );
`else
  logic unused_claim;
  assign unused_claim = ^{claim_en, claim_reg};
  assign busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int LIM = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_req = 1'b0, mem_req = 1'b0, claim_en = 1'b0;
  logic [3:0]  alu_dst = '0, mem_dst = '0, claim_reg = '0;
  logic [31:0] alu_val = '0, mem_val = '0;
  logic        alu_gnt, mem_gnt, wb_en, pc_wb_err;
  logic [3:0]  dst;
  logic [31:0] wb_val;
  logic [14:0] busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_dst(alu_dst), .alu_val(alu_val), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_dst(mem_dst), .mem_val(mem_val), .mem_gnt(mem_gnt),
    .wb_en(wb_en), .dst(dst), .wb_val(wb_val),
    .claim_en(claim_en), .claim_reg(claim_reg), .busy(busy), .pc_wb_err(pc_wb_err)
  );

  typedef struct packed { logic err; logic [3:0] d; logic [31:0] v; } wr_t;

  wr_t   expq[$];
  int    total = 0, bad = 0;

  // reference model state
  int    denied = 0;
  bit [14:0] mbusy = '0;
  bit    pend_v = 0;
  wr_t   pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] exp_busy();
`ifdef REGFILE_WB_SCOREBOARD_EN
    return mbusy;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    denied = 0; mbusy = '0; pend_v = 0;
    expq.delete();
  endtask

  // One clock cycle: drive, check grants/busy against the model, then
  // advance the model across the coming edge.
  task automatic cyc(input bit ar, input logic [3:0] ad, input logic [31:0] av,
                     input bit mr, input logic [3:0] md, input logic [31:0] mv,
                     input bit ce, input logic [3:0] cr,
                     output bit ag, output bit mg);
    bit  starved;
    wr_t w;
    @(posedge clk); #1;
    alu_req = ar; alu_dst = ad; alu_val = av;
    mem_req = mr; mem_dst = md; mem_val = mv;
    claim_en = ce; claim_reg = cr;
    #3;
    starved = ar && (denied >= LIM);
    mg = mr && !starved;
    ag = ar && !mg;
    chk("alu_gnt", alu_gnt, ag);
    chk("mem_gnt", mem_gnt, mg);
    chk("busy", busy, exp_busy());
    if (pend_v && pend.d != 4'd15) mbusy[pend.d] = 1'b0;
    if (ce && cr != 4'd15)         mbusy[cr] = 1'b1;
    denied = (ar && !ag) ? ((denied < LIM) ? denied + 1 : LIM) : 0;
    pend_v = ag || mg;
    if (pend_v) begin
      w.d = ag ? ad : md;
      w.v = ag ? av : mv;
      w.err = (w.d == 4'd15);
      expq.push_back(w);
      pend = w;
    end
  endtask

  task automatic idle(input bit ce, input logic [3:0] cr);
    bit ag, mg;
    cyc(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, ce, cr, ag, mg);
  endtask

  // monitor: pops the scoreboard whenever the write port shows activity
  initial begin
    wr_t         w;
    logic [3:0]  hold_d = '0;
    logic [31:0] hold_v = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_d = '0; hold_v = '0;
        chk("rst_wb_en", wb_en, 0);
        chk("rst_pc_wb_err", pc_wb_err, 0);
        chk("rst_dst", dst, 0);
        chk("rst_wb_val", wb_val, 0);
        chk("rst_busy", busy, 0);
      end else if (wb_en || pc_wb_err) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: wb_en=%0b pc_wb_err=%0b dst=%0d, none expected at %0t",
                   wb_en, pc_wb_err, dst, $time);
        end else begin
          w = expq.pop_front();
          chk("wb_en", wb_en, !w.err);
          chk("pc_wb_err", pc_wb_err, w.err);
          if (!w.err) begin hold_d = w.d; hold_v = w.v; end
          chk("dst", dst, hold_d);
          chk("wb_val", wb_val, hold_v);
        end
      end else begin
        chk("dst_hold", dst, hold_d);
        chk("wb_val_hold", wb_val, hold_v);
      end
    end
  end

  initial begin
    bit          ag, mg;
    bit          ap = 0, mp = 0;
    logic [3:0]  ad = '0, md = '0;
    logic [31:0] av = '0, mv = '0;

    // reset: requests and a claim present, nothing may respond
    alu_req = 1; mem_req = 1; claim_en = 1; claim_reg = 4'd5;
    repeat (2) @(negedge clk);
    chk("rst_alu_gnt", alu_gnt, 0);
    chk("rst_mem_gnt", mem_gnt, 0);
    alu_req = 0; mem_req = 0; claim_en = 0;
    @(negedge clk); #1 rst = 1;

    // single ALU write granted in the first cycle after release
    cyc(1, 4'd3, 32'h0000_00AA, 0, 4'd0, 32'd0, 0, 4'd0, ag, mg);
    idle(0, 4'd0);

    // both requesting: MEM x3, then starved ALU, then counter restarted
    repeat (4) cyc(1, 4'd7, 32'h77, 1, 4'd9, 32'h99, 0, 4'd0, ag, mg);
    cyc(1, 4'd7, 32'h78, 1, 4'd9, 32'h9A, 0, 4'd0, ag, mg);
    idle(0, 4'd0);

    // load to the PC index
    cyc(0, 4'd0, 32'd0, 1, 4'd15, 32'hDEAD_BEEF, 0, 4'd0, ag, mg);
    idle(0, 4'd0);
    idle(0, 4'd0);

    // claim R5, write R5, re-claim on the wb_en edge: stays busy
    idle(1, 4'd5);
    cyc(1, 4'd5, 32'h55, 0, 4'd0, 32'd0, 0, 4'd0, ag, mg);
    idle(1, 4'd5);
    idle(0, 4'd0);
    // write R5 with no new claim: clears after wb_en
    cyc(1, 4'd5, 32'h56, 0, 4'd0, 32'd0, 0, 4'd0, ag, mg);
    idle(0, 4'd0);
    idle(0, 4'd0);
    // claim of R15 ignored, R14 boundary accepted
    idle(1, 4'd15);
    idle(1, 4'd14);
    idle(0, 4'd0);

    // reset the cycle after a grant: the pending write is dropped
    cyc(1, 4'd2, 32'h22, 0, 4'd0, 32'd0, 0, 4'd0, ag, mg);
    @(posedge clk); #1;
    rst = 0; alu_req = 1; mem_req = 1; mem_dst = 4'd4; claim_en = 1; claim_reg = 4'd6;
    model_reset();
    #3;
    chk("rst2_alu_gnt", alu_gnt, 0);
    chk("rst2_mem_gnt", mem_gnt, 0);
    repeat (2) @(negedge clk);
    #1;
    alu_req = 0; mem_req = 0; claim_en = 0;
    rst = 1;
    idle(0, 4'd0);
    idle(0, 4'd0);

    // random traffic; each requester holds its request until granted
    for (int i = 0; i < 400; i++) begin
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1; ad = 4'($urandom_range(0, 15)); av = $urandom;
      end
      if (!mp && $urandom_range(0, 1) != 0) begin
        mp = 1; md = 4'($urandom_range(0, 15)); mv = $urandom;
      end
      cyc(ap, ad, av, mp, md, mv, $urandom_range(0, 3) == 0,
          4'($urandom_range(0, 15)), ag, mg);
      if (ag) ap = 0;
      if (mg) mp = 0;
    end
    idle(0, 4'd0);
    idle(0, 4'd0);
    @(negedge clk); #1;
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
